filter_scratch_reader: RTL and testbench

//  Read-side sequencer for the filter scratchpad: walks read addresses, drives read_en/chip_en,

---
 rtl/filter_scratch_pkg.sv | 16 +
 rtl/fsr_skid_fifo.sv | 47 ++++
 rtl/filter_scratch_reader.sv | 170 +++++++++++++++++
 tb/tb_filter_scratch_reader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/filter_scratch_pkg.sv
// Shared types and constants for the filter scratchpad read sequencer.
package filter_scratch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } fsr_state_t;

    // Output FIFO depth: one slot for the word in flight, one for the word being held.
    localparam int unsigned FSR_FIFO_DEPTH = 2;
    localparam int unsigned FSR_CNT_W      = $clog2(FSR_FIFO_DEPTH + 1);
    localparam int unsigned FSR_PTR_W      = $clog2(FSR_FIFO_DEPTH);

endpackage

// File: rtl/fsr_skid_fifo.sv
// Two-entry FIFO of {last, data} words absorbing the scratchpad's read latency.
module fsr_skid_fifo
    import filter_scratch_pkg::*;
#(
    parameter int unsigned WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_word,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head,
    output logic [FSR_CNT_W-1:0] count
);

    logic [WIDTH-1:0]     mem [FSR_FIFO_DEPTH];
    logic [FSR_PTR_W-1:0] wr_ptr;
    logic [FSR_PTR_W-1:0] rd_ptr;

    // Storage, pointers and occupancy; push and pop in the same cycle leave count unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < FSR_FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_word;
                wr_ptr      <= wr_ptr + FSR_PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FSR_PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + FSR_CNT_W'(1);
            end else if (!push && pop) begin
                count <= count - FSR_CNT_W'(1);
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/filter_scratch_reader.sv
// Read-side sequencer for the filter scratchpad: walks addresses behind the
// write pointer on the first pass, replays the filter num_passes times and
// streams words over valid/ready.
// Optional: FILTER_READER_STALL_CNT_EN adds the stall_cycles counter output.
module filter_scratch_reader
    import filter_scratch_pkg::*;
#(
    parameter int unsigned SCRATCH_WIDTH        = 8,
    parameter int unsigned SCRATCH_ADDRESS_SIZE = 8,
    parameter int unsigned PASS_WIDTH           = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [SCRATCH_ADDRESS_SIZE-1:0] start_addr,
    input  logic [SCRATCH_ADDRESS_SIZE-1:0] filter_len,
    input  logic [PASS_WIDTH-1:0]           num_passes,
    input  logic [SCRATCH_ADDRESS_SIZE-1:0] last_write,
    output logic                            read_en,
    output logic                            chip_en,
    output logic [SCRATCH_ADDRESS_SIZE-1:0] read_addr,
    input  logic [SCRATCH_WIDTH-1:0]        scr_dout,
    output logic [SCRATCH_WIDTH-1:0]        dout,
    output logic                            dout_valid,
    input  logic                            dout_ready,
    output logic                            dout_last,
`ifdef FILTER_READER_STALL_CNT_EN
    output logic [31:0]                     stall_cycles,
`endif
    output logic                            busy,
    output logic                            done
);

    localparam int unsigned A = SCRATCH_ADDRESS_SIZE;
    localparam int unsigned P = PASS_WIDTH;
    localparam int unsigned W = SCRATCH_WIDTH;

    fsr_state_t state_q, state_d;

    logic [A-1:0] start_addr_q, len_q, idx_q;
    logic [P-1:0] passes_q, pass_q;
    logic         inflight_q, inflight_last_q;

    logic [FSR_CNT_W-1:0] fifo_count;
    logic [W:0]           fifo_head;
    logic                 fifo_empty, fifo_push, fifo_pop;

    logic         issue, data_ok, credit_ok, idx_last, pass_last, accept, drain_done;
    logic [A-1:0] written_span;

    assign written_span = last_write - start_addr_q;
    assign data_ok      = (pass_q != '0) || (idx_q < written_span);
    assign credit_ok    = (fifo_count + FSR_CNT_W'(inflight_q)) < FSR_CNT_W'(FSR_FIFO_DEPTH);
    assign issue        = (state_q == ST_READ) && data_ok && credit_ok;
    assign idx_last     = (idx_q == len_q - A'(1));
    assign pass_last    = (pass_q == passes_q - P'(1));

    // The in-flight word bypasses the FIFO when it is empty and the consumer is ready;
    // otherwise it is parked, so the FIFO only ever holds words the consumer refused.
    assign fifo_empty = (fifo_count == '0);
    assign fifo_pop   = !fifo_empty && dout_ready;
    assign fifo_push  = inflight_q && !(fifo_empty && dout_ready);
    assign dout_valid = !fifo_empty || inflight_q;
    assign accept     = dout_valid && dout_ready;
    assign dout       = !dout_valid ? '0   : (fifo_empty ? scr_dout        : fifo_head[W-1:0]);
    assign dout_last  = !dout_valid ? 1'b0 : (fifo_empty ? inflight_last_q : fifo_head[W]);
    assign read_addr  = start_addr_q + idx_q;

    // Drain completes when nothing will remain after this cycle's accept.
    assign drain_done = inflight_q ? (fifo_empty && dout_ready)
                                   : (fifo_empty || ((fifo_count == FSR_CNT_W'(1)) && dout_ready));

    fsr_skid_fifo #(
        .WIDTH(W + 1)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifo_push),
        .push_word({inflight_last_q, scr_dout}),
        .pop      (fifo_pop),
        .head     (fifo_head),
        .count    (fifo_count)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ((filter_len == '0) || (num_passes == '0)) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (issue && idx_last && pass_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        read_en = issue;
        chip_en = issue;
        busy    = (state_q == ST_READ) || (state_q == ST_DRAIN);
        done    = (state_q == ST_DONE);
    end

    // Job latch, address/pass walk and in-flight tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_addr_q    <= '0;
            len_q           <= '0;
            passes_q        <= '0;
            idx_q           <= '0;
            pass_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            if ((state_q == ST_IDLE) && start) begin
                start_addr_q <= start_addr;
                len_q        <= filter_len;
                passes_q     <= num_passes;
                idx_q        <= '0;
                pass_q       <= '0;
            end else if (issue) begin
                if (idx_last) begin
                    idx_q  <= '0;
                    pass_q <= pass_q + P'(1);
                end else begin
                    idx_q <= idx_q + A'(1);
                end
            end
            inflight_q      <= issue;
            inflight_last_q <= issue && idx_last;
        end
    end

`ifdef FILTER_READER_STALL_CNT_EN
    // Saturating count of busy cycles with neither a read issued nor a word accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            stall_cycles <= '0;
        end else if (busy && !issue && !accept && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
`endif

endmodule

// File: tb/tb_filter_scratch_reader.sv
// Scoreboard bench for filter_scratch_reader: stimulus queues expected
// addresses and words, a negedge monitor compares them as the DUT presents them.
module tb_filter_scratch_reader;

    localparam int W = 8;
    localparam int A = 8;
    localparam int P = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [A-1:0] start_addr = '0;
    logic [A-1:0] filter_len = '0;
    logic [P-1:0] num_passes = '0;
    logic [A-1:0] last_write = '0;
    logic         read_en, chip_en;
    logic [A-1:0] read_addr;
    logic [W-1:0] scr_dout = '0;
    logic [W-1:0] dout;
    logic         dout_valid, dout_last, busy, done;
    logic         dout_ready = 1'b1;
`ifdef FILTER_READER_STALL_CNT_EN
    logic [31:0]  stall_cycles;
`endif

    filter_scratch_reader #(
        .SCRATCH_WIDTH       (W),
        .SCRATCH_ADDRESS_SIZE(A),
        .PASS_WIDTH          (P)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .start_addr  (start_addr),
        .filter_len  (filter_len),
        .num_passes  (num_passes),
        .last_write  (last_write),
        .read_en     (read_en),
        .chip_en     (chip_en),
        .read_addr   (read_addr),
        .scr_dout    (scr_dout),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout_last   (dout_last),
`ifdef FILTER_READER_STALL_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Scratchpad contents: nibble swap xor 0x3C, distinct for every address.
    function automatic logic [7:0] pat(input logic [7:0] a);
        return {a[3:0], a[7:4]} ^ 8'h3C;
    endfunction

    // One-cycle-latency scratchpad.
    always @(posedge clk) if (read_en) scr_dout <= pat(read_addr);

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    logic [A-1:0] addr_q[$];
    logic [W:0]   word_q[$];

    int           cyc = 0;
    int           first_rd, first_vld, done_cyc, rd_cnt, out_cnt, max_out, done_cnt, cur_len;
    bit           done_seen, held_v;
    logic [W:0]   held;
    logic [A-1:0] cur_start;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares reads and accepted words against the scoreboard queues.
    always @(negedge clk) begin
        if (rst) begin
            if (read_en) begin
                chk("chip_en", chip_en, 1);
                if (addr_q.size() == 0) chk("unexpected_read", read_addr, 32'hFFFF_FFFF);
                else chk("read_addr", read_addr, addr_q.pop_front());
                if (rd_cnt < cur_len)
                    chk("first_pass_gate", (read_addr - cur_start) < (last_write - cur_start), 1);
                if (first_rd < 0) first_rd = cyc;
                rd_cnt++;
            end
            if (held_v) chk("hold_stable", {dout_valid, dout_last, dout}, {1'b1, held});
            held_v = dout_valid && !dout_ready;
            held   = {dout_last, dout};
            if (dout_valid && first_vld < 0) first_vld = cyc;
            if (dout_valid && dout_ready) begin
                if (word_q.size() == 0) chk("unexpected_word", {dout_last, dout}, 32'hFFFF_FFFF);
                else chk("word", {dout_last, dout}, word_q.pop_front());
            end
            out_cnt += int'(read_en) - int'(dout_valid && dout_ready);
            if (out_cnt > max_out) max_out = out_cnt;
            if (done) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                done_cnt++;
            end
        end
    end

    task automatic clear_mon();
        first_rd = -1; first_vld = -1; done_cyc = -1; rd_cnt = 0; out_cnt = 0;
        max_out = 0; done_cnt = 0; done_seen = 1'b0; held_v = 1'b0;
        addr_q.delete(); word_q.delete();
    endtask

    task automatic load_job(input logic [7:0] sa, input logic [7:0] len,
                            input logic [7:0] np, input logic [7:0] lw);
        clear_mon();
        cur_start = sa; cur_len = int'(len);
        for (int p = 0; p < int'(np); p++)
            for (int i = 0; i < int'(len); i++) begin
                logic [7:0] a;
                a = sa + 8'(i);
                addr_q.push_back(a);
                word_q.push_back({(i == int'(len) - 1), pat(a)});
            end
        start_addr = sa; filter_len = len; num_passes = np; last_write = lw;
    endtask

    task automatic pulse_start(output int t0);
        @(posedge clk); #1;
        start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run(input string tag, input logic [7:0] sa, input logic [7:0] len,
                       input logic [7:0] np, input logic [7:0] lw, input bit lw_step,
                       input int rl_from, input int rl_len, output int t0);
        load_job(sa, len, np, lw);
        pulse_start(t0);
        for (int c = 1; c < 400 && !done_seen; c++) begin
            if (lw_step && (c % 5 == 0)) last_write = last_write + 8'd1;
            dout_ready = !(c >= rl_from && c < rl_from + rl_len);
            @(posedge clk); #1;
        end
        dout_ready = 1'b1;
        chk({tag, "_done_seen"}, done_seen, 1);
        chk({tag, "_words_left"}, word_q.size(), 0);
        chk({tag, "_addrs_left"}, addr_q.size(), 0);
        chk({tag, "_outstanding_le2"}, max_out <= 2, 1);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, "_done_pulses"}, done_cnt, 1);
        chk({tag, "_busy_idle"}, busy, 0);
    endtask

    initial begin
        int t0;
        clear_mon();
        cur_len = 0; cur_start = '0;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_read_en", read_en, 0);
        chk("rst_outputs", {chip_en, dout_valid, dout_last, busy, done}, 0);
        chk("rst_read_addr", read_addr, 0);
        chk("rst_dout", dout, 0);
        @(posedge clk); #1 rst = 1'b1;

        // 1: basic single pass, latency and done timing
        run("t1", 8'h10, 8'd4, 8'd1, 8'h20, 1'b0, 0, 0, t0);
        chk("t1_first_read_cyc", first_rd - t0, 1);
        chk("t1_first_valid_cyc", first_vld - t0, 2);
        chk("t1_done_cyc", done_cyc - t0, 6);
        chk("t1_reads", rd_cnt, 4);

        // 2: two passes, replayed addresses, last on each pass
        run("t2", 8'h10, 8'd3, 8'd2, 8'h20, 1'b0, 0, 0, t0);
        chk("t2_reads", rd_cnt, 6);

        // 3: write pointer trailing the reader
        run("t3", 8'h40, 8'd4, 8'd1, 8'h41, 1'b1, 0, 0, t0);
        chk("t3_reads", rd_cnt, 4);

        // 4: consumer back-pressure mid-stream
        run("t4", 8'h30, 8'd6, 8'd1, 8'h40, 1'b0, 3, 4, t0);
        chk("t4_reads", rd_cnt, 6);

        // 5: address wrap, write pointer exactly at the end of the filter
        run("t5", 8'hFE, 8'd4, 8'd1, 8'h02, 1'b0, 0, 0, t0);
        chk("t5_reads", rd_cnt, 4);

        // 6a: reset during READ aborts with outputs cleared and no done
        load_job(8'h50, 8'd8, 8'd1, 8'h60);
        pulse_start(t0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("t6_abort_read_en", read_en, 0);
        chk("t6_abort_outputs", {chip_en, dout_valid, dout_last, busy, done}, 0);
        chk("t6_abort_addr_dout", {read_addr, dout}, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("t6_abort_no_done", done_seen, 0);
        clear_mon();
        rst = 1'b1;

        // 6b: zero-length filter completes straight away
        load_job(8'h10, 8'd0, 8'd1, 8'h20);
        pulse_start(t0);
        repeat (3) @(posedge clk);
        #1;
        chk("t6_len0_done_cyc", done_cyc - t0, 1);
        chk("t6_len0_reads", rd_cnt, 0);
        chk("t6_len0_done_pulses", done_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
